// File: rtl/progmem_port_arbiter.sv
// progmem_port_arbiter: round-robin arbiter/sequencer for program RAM port A.
// Serialises single-word reads and writes from two requesters, with optional lock.
module progmem_port_arbiter #(
   parameter int ADDR_WIDTH = 10,
   parameter int DATA_WIDTH = 16,
   parameter int RD_LATENCY = 2
) (
   input  logic                  sysclk,
   input  logic                  sysreset,
   input  logic                  req0,
   input  logic                  req1,
   input  logic                  we0,
   input  logic                  we1,
   input  logic                  lock0,
   input  logic                  lock1,
   input  logic [ADDR_WIDTH-1:0] addr0,
   input  logic [ADDR_WIDTH-1:0] addr1,
   input  logic [DATA_WIDTH-1:0] wdata0,
   input  logic [DATA_WIDTH-1:0] wdata1,
   output logic                  ack0,
   output logic                  ack1,
   output logic                  rvalid0,
   output logic                  rvalid1,
   output logic [DATA_WIDTH-1:0] rdata0,
   output logic [DATA_WIDTH-1:0] rdata1,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   output logic [DATA_WIDTH-1:0] ram_wdata,
   output logic                  ram_wren,
   input  logic [DATA_WIDTH-1:0] ram_q,
   output logic                  busy
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      READ  = 2'd2
   } state_t;

   localparam logic [1:0] CNT_INIT = 2'(RD_LATENCY - 1);

   state_t state_q, state_d;
   logic [1:0] cnt_q, cnt_d;
   logic last_q, last_d;
   logic lock_q, lock_d;
   logic lock_id_q, lock_id_d;
   logic gnt_q, gnt_d;

   logic lock_req;
   logic sel_valid;
   logic sel_id;
   logic sel_we;
   logic sel_lock;
   logic [ADDR_WIDTH-1:0] sel_addr;
   logic [DATA_WIDTH-1:0] sel_wdata;

   logic ack0_d, ack1_d;
   logic rvalid0_d, rvalid1_d;
   logic [DATA_WIDTH-1:0] rdata0_d, rdata1_d;
   logic [ADDR_WIDTH-1:0] ram_addr_d;
   logic [DATA_WIDTH-1:0] ram_wdata_d;
   logic ram_wren_d;
   logic busy_d;

   // Winner selection: held lock first, then sole requester, then round-robin.
   always_comb begin
      lock_req  = lock_id_q ? req1 : req0;
      sel_valid = req0 | req1;
      if (lock_q && lock_req) begin
         sel_id = lock_id_q;
      end else if (req0 && req1) begin
         sel_id = ~last_q;
      end else begin
         sel_id = req1;
      end
      sel_we    = sel_id ? we1    : we0;
      sel_lock  = sel_id ? lock1  : lock0;
      sel_addr  = sel_id ? addr1  : addr0;
      sel_wdata = sel_id ? wdata1 : wdata0;
   end

   // State, round-robin, lock and registered outputs.
   always_ff @(posedge sysclk or posedge sysreset) begin
      if (sysreset) begin
         state_q   <= IDLE;
         cnt_q     <= 2'd0;
         last_q    <= 1'b1;
         lock_q    <= 1'b0;
         lock_id_q <= 1'b0;
         gnt_q     <= 1'b0;
         ack0      <= 1'b0;
         ack1      <= 1'b0;
         rvalid0   <= 1'b0;
         rvalid1   <= 1'b0;
         rdata0    <= '0;
         rdata1    <= '0;
         ram_addr  <= '0;
         ram_wdata <= '0;
         ram_wren  <= 1'b0;
         busy      <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         last_q    <= last_d;
         lock_q    <= lock_d;
         lock_id_q <= lock_id_d;
         gnt_q     <= gnt_d;
         ack0      <= ack0_d;
         ack1      <= ack1_d;
         rvalid0   <= rvalid0_d;
         rvalid1   <= rvalid1_d;
         rdata0    <= rdata0_d;
         rdata1    <= rdata1_d;
         ram_addr  <= ram_addr_d;
         ram_wdata <= ram_wdata_d;
         ram_wren  <= ram_wren_d;
         busy      <= busy_d;
      end
   end

   // Next state: issue from IDLE, one-cycle WRITE, counted READ.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      last_d    = last_q;
      lock_d    = lock_q;
      lock_id_d = lock_id_q;
      gnt_d     = gnt_q;
      unique case (state_q)
         IDLE: begin
            if (lock_q && !lock_req) begin
               lock_d = 1'b0;
            end
            if (sel_valid) begin
               state_d   = sel_we ? WRITE : READ;
               cnt_d     = CNT_INIT;
               last_d    = sel_id;
               gnt_d     = sel_id;
               lock_d    = sel_lock;
               lock_id_d = sel_id;
            end
         end
         WRITE: begin
            state_d = IDLE;
         end
         READ: begin
            if (cnt_q == 2'd0) begin
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q - 2'd1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Output next values: ack/RAM drive on issue, rdata/rvalid on read completion.
   always_comb begin
      ack0_d      = 1'b0;
      ack1_d      = 1'b0;
      rvalid0_d   = 1'b0;
      rvalid1_d   = 1'b0;
      rdata0_d    = rdata0;
      rdata1_d    = rdata1;
      ram_addr_d  = ram_addr;
      ram_wdata_d = ram_wdata;
      ram_wren_d  = 1'b0;
      busy_d      = (state_d != IDLE);
      if (state_q == IDLE && sel_valid) begin
         ram_addr_d  = sel_addr;
         ram_wdata_d = sel_wdata;
         ram_wren_d  = sel_we;
         ack0_d      = ~sel_id;
         ack1_d      = sel_id;
      end
      if (state_q == READ && cnt_q == 2'd0) begin
         if (gnt_q) begin
            rvalid1_d = 1'b1;
            rdata1_d  = ram_q;
         end else begin
            rvalid0_d = 1'b1;
            rdata0_d  = ram_q;
         end
      end
   end

endmodule
